// File: rtl/nz_pair_sel_gen.sv
// Nonzero-pair sequencer: takes one operand group plus a nonzero bitmap and emits one beat per nonzero pair.
// Optional feature: define NZ_BEAT_IDX_EN to add the out_beat_idx output (beat number within the group).
//   state | meaning
//   IDLE  | waiting for a group; in_ready high once out of reset
//   EMIT  | presenting beats decoded from the remaining-mask register
module nz_pair_sel_gen #(
  parameter int DW_DATA = 8,
  parameter int NUM_IN  = 4,
  parameter int SEL_IN  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW_DATA*NUM_IN-1:0] in_data,
  input  logic [NUM_IN-1:0]         in_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_DATA*NUM_IN-1:0] out_data,
  output logic [SEL_IN*2-1:0]       out_sel,
  output logic [1:0]                out_pair_mask,
  output logic                      out_last
`ifdef NZ_BEAT_IDX_EN
  ,
  output logic [SEL_IN-1:0]         out_beat_idx
`endif
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t              state;
  logic                rdy_en;
  logic [NUM_IN-1:0]   rem;
  logic [NUM_IN-1:0]   low1;
  logic [NUM_IN-1:0]   rest1;
  logic [NUM_IN-1:0]   low2;
  logic [NUM_IN-1:0]   rem_next;
  logic [SEL_IN-1:0]   left_idx;
  logic [SEL_IN-1:0]   right_idx;
  logic                beat_done;
  logic                accept;

  // Two lowest set bits isolated with the x & -x trick; both are one-hot or zero.
  always_comb begin
    low1      = rem & (-rem);
    rest1     = rem & ~low1;
    low2      = rest1 & (-rest1);
    rem_next  = rest1 & ~low2;
    left_idx  = '0;
    right_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (low1[i]) left_idx  = SEL_IN'(i);
      if (low2[i]) right_idx = SEL_IN'(i);
    end
  end

  assign out_valid     = (state == EMIT);
  assign out_sel       = {right_idx, left_idx};
  assign out_pair_mask = {|rest1, |rem};
  assign out_last      = (state == EMIT) && (rem_next == '0);

  assign beat_done = out_valid && out_ready;
  // rdy_en holds in_ready low until the first edge after reset release.
  assign in_ready  = rdy_en && ((state == IDLE) || (beat_done && out_last));
  assign accept    = in_valid && in_ready;

`ifdef NZ_BEAT_IDX_EN
  logic [SEL_IN-1:0] beat_idx;
  assign out_beat_idx = beat_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_en   <= 1'b0;
      rem      <= '0;
      out_data <= '0;
`ifdef NZ_BEAT_IDX_EN
      beat_idx <= '0;
`endif
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        state    <= EMIT;
        rem      <= in_mask;
        out_data <= in_data;
`ifdef NZ_BEAT_IDX_EN
        beat_idx <= '0;
`endif
      end else if (beat_done) begin
        rem <= rem_next;
        if (out_last) begin
          state <= IDLE;
        end else begin
`ifdef NZ_BEAT_IDX_EN
          beat_idx <= beat_idx + 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_nz_pair_sel_gen.sv
// Directed bench for nz_pair_sel_gen; beat-index checks are active when NZ_BEAT_IDX_EN is defined.
module tb_nz_pair_sel_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sel;
  logic [1:0]  out_pair_mask;
  logic        out_last;
`ifdef NZ_BEAT_IDX_EN
  logic [1:0]  out_beat_idx;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nz_pair_sel_gen #(.DW_DATA(8), .NUM_IN(4), .SEL_IN(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_mask       (in_mask),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sel       (out_sel),
    .out_pair_mask (out_pair_mask),
    .out_last      (out_last)
`ifdef NZ_BEAT_IDX_EN
    ,
    .out_beat_idx  (out_beat_idx)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks valid, select {right,left}, pair mask and last in one call.
  task automatic chk_beat(input string tag, input logic v, input logic [3:0] sel,
                          input logic [1:0] pm, input logic last);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".sel"}, 64'(out_sel), 64'(sel));
    chk({tag, ".pm"}, 64'(out_pair_mask), 64'(pm));
    chk({tag, ".last"}, 64'(out_last), 64'(last));
  endtask

  task automatic chk_idx(input string tag, input logic [1:0] exp);
`ifdef NZ_BEAT_IDX_EN
    chk({tag, ".beat_idx"}, 64'(out_beat_idx), 64'(exp));
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.sel", 64'(out_sel), 64'd0);
    chk("rst.pm", 64'(out_pair_mask), 64'd0);
    chk("rst.last", 64'(out_last), 64'd0);
    chk("rst.data", 64'(out_data), 64'd0);
    chk_idx("rst", 2'd0);
    #9 rst_n = 1'b1;
    #1;
    chk("rel.in_ready_before_edge", 64'(in_ready), 64'd0);
    step();
    chk("rel.in_ready", 64'(in_ready), 64'd1);

    // T1: mask 1011
    in_valid  = 1'b1;
    in_data   = 32'h44332211;
    in_mask   = 4'b1011;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t1.b0", 1'b1, 4'b0100, 2'b11, 1'b0);
    chk("t1.data", 64'(out_data), 64'h44332211);
    chk("t1.b0.in_ready", 64'(in_ready), 64'd0);
    chk_idx("t1.b0", 2'd0);
    step();
    chk_beat("t1.b1", 1'b1, 4'b0011, 2'b01, 1'b1);
    chk("t1.b1.in_ready", 64'(in_ready), 64'd1);
    chk_idx("t1.b1", 2'd1);
    step();
    chk("t1.end.valid", 64'(out_valid), 64'd0);
    chk("t1.end.in_ready", 64'(in_ready), 64'd1);

    // T2: empty group
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    in_mask  = 4'b0000;
    step();
    in_valid = 1'b0;
    in_data  = 32'h12345678;
    chk_beat("t2.b0", 1'b1, 4'b0000, 2'b00, 1'b1);
    chk("t2.data", 64'(out_data), 64'hDEADBEEF);
    step();
    chk("t2.end.valid", 64'(out_valid), 64'd0);
    chk("t2.hold.data", 64'(out_data), 64'hDEADBEEF);

    // T3: full mask with stall
    in_valid  = 1'b1;
    in_data   = 32'h0A0B0C0D;
    in_mask   = 4'b1111;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_beat("t3.stall", 1'b1, 4'b0100, 2'b11, 1'b0);
      chk("t3.stall.in_ready", 64'(in_ready), 64'd0);
      chk_idx("t3.stall", 2'd0);
      step();
    end
    out_ready = 1'b1;
    chk_beat("t3.b0", 1'b1, 4'b0100, 2'b11, 1'b0);
    step();
    chk_beat("t3.b1", 1'b1, 4'b1110, 2'b11, 1'b1);
    chk("t3.data", 64'(out_data), 64'h0A0B0C0D);
    chk_idx("t3.b1", 2'd1);
    step();
    chk("t3.end.valid", 64'(out_valid), 64'd0);

    // T4: back-to-back groups, B accepted on A's last beat
    in_valid = 1'b1;
    in_data  = 32'hA1A2A3A4;
    in_mask  = 4'b0110;
    step();
    chk_beat("t4.a", 1'b1, 4'b1001, 2'b11, 1'b1);
    chk("t4.a.data", 64'(out_data), 64'hA1A2A3A4);
    chk_idx("t4.a", 2'd0);
    in_data = 32'hB1B2B3B4;
    in_mask = 4'b1000;
    chk("t4.a.in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk_beat("t4.b", 1'b1, 4'b0011, 2'b01, 1'b1);
    chk("t4.b.data", 64'(out_data), 64'hB1B2B3B4);
    chk_idx("t4.b", 2'd0);
    step();
    chk("t4.end.valid", 64'(out_valid), 64'd0);

    // T5: reset mid-group
    in_valid = 1'b1;
    in_data  = 32'h55667788;
    in_mask  = 4'b1111;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5.pre.valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.async.valid", 64'(out_valid), 64'd0);
    chk("t5.async.in_ready", 64'(in_ready), 64'd0);
    chk("t5.async.data", 64'(out_data), 64'd0);
    chk("t5.async.pm", 64'(out_pair_mask), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5.rel.in_ready", 64'(in_ready), 64'd0);
    step();
    chk("t5.after.in_ready", 64'(in_ready), 64'd1);
    chk("t5.after.valid", 64'(out_valid), 64'd0);
    in_valid  = 1'b1;
    in_data   = 32'h000000EE;
    in_mask   = 4'b0001;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk_beat("t5.b0", 1'b1, 4'b0000, 2'b01, 1'b1);
    chk("t5.data", 64'(out_data), 64'h000000EE);
    step();
    chk("t5.end.valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
